// File: rtl/id_operand_stage_if.sv
// Decode-side bus of the ID operand stage: decoded fields, regfile read data,
// forwarding sources in, and the registered ID/EX fields out.
interface id_operand_stage_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_FWD  = 2,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
);
   logic                      dec_valid;
   logic                      dec_reg1_read;
   logic                      dec_reg2_read;
   logic [ADDR_W-1:0]         dec_reg1_addr;
   logic [ADDR_W-1:0]         dec_reg2_addr;
   logic [DATA_W-1:0]         dec_imm;
   logic [ALUOP_W-1:0]        dec_aluop;
   logic [ALUSEL_W-1:0]       dec_alusel;
   logic [ADDR_W-1:0]         dec_wd;
   logic                      dec_wreg;
   logic                      dec_is_load;
   logic                      dec_is_branch;
   logic [DATA_W-1:0]         reg1_data_i;
   logic [DATA_W-1:0]         reg2_data_i;
   logic [NUM_FWD-1:0]        fwd_wreg_i;
   logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i;
   logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
   logic [NUM_FWD-1:0]        fwd_is_load_i;

   logic                      ex_valid_o;
   logic [ALUOP_W-1:0]        ex_aluop_o;
   logic [ALUSEL_W-1:0]       ex_alusel_o;
   logic [DATA_W-1:0]         ex_reg1_o;
   logic [DATA_W-1:0]         ex_reg2_o;
   logic [ADDR_W-1:0]         ex_wd_o;
   logic                      ex_wreg_o;
   logic                      ex_is_load_o;
   logic                      ex_in_delayslot_o;

   modport master (
      output dec_valid, dec_reg1_read, dec_reg2_read, dec_reg1_addr, dec_reg2_addr,
             dec_imm, dec_aluop, dec_alusel, dec_wd, dec_wreg, dec_is_load,
             dec_is_branch, reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_wd_i,
             fwd_wdata_i, fwd_is_load_i,
      input  ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
             ex_wreg_o, ex_is_load_o, ex_in_delayslot_o
   );

   modport slave (
      input  dec_valid, dec_reg1_read, dec_reg2_read, dec_reg1_addr, dec_reg2_addr,
             dec_imm, dec_aluop, dec_alusel, dec_wd, dec_wreg, dec_is_load,
             dec_is_branch, reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_wd_i,
             fwd_wdata_i, fwd_is_load_i,
      output ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
             ex_wreg_o, ex_is_load_o, ex_in_delayslot_o
   );
endinterface

// File: rtl/id_operand_stage.sv
// ID operand stage: resolves source operands (imm / r0 / prioritised forwarding /
// regfile), raises load-use stall requests and registers the result into ID/EX.
module id_operand_stage #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_FWD  = 2,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   id_operand_stage_if.slave bus,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             stallreq_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              load_hit;
   } operand_t;

   typedef struct packed {
      logic                valid;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic [ADDR_W-1:0]   wd;
      logic                wreg;
      logic                is_load;
      logic                in_ds;
   } idex_t;

   // Priority selects the youngest matching source; its load flag alone decides the hazard.
   function automatic operand_t resolve(
      input logic                      rd,
      input logic [ADDR_W-1:0]         addr,
      input logic [DATA_W-1:0]         rf_data,
      input logic [DATA_W-1:0]         imm,
      input logic [NUM_FWD-1:0]        wreg,
      input logic [NUM_FWD*ADDR_W-1:0] wd,
      input logic [NUM_FWD*DATA_W-1:0] wdata,
      input logic [NUM_FWD-1:0]        is_load
   );
      operand_t res;
      logic     found;
      res.data     = rf_data;
      res.load_hit = 1'b0;
      found        = 1'b0;
      if (!rd) begin
         res.data = imm;
      end else if (addr == '0) begin
         res.data = '0;
      end else begin
         for (int k = 0; k < NUM_FWD; k++) begin
            if (!found && wreg[k] && (wd[k*ADDR_W +: ADDR_W] == addr)) begin
               found        = 1'b1;
               res.data     = wdata[k*DATA_W +: DATA_W];
               res.load_hit = is_load[k];
            end
         end
      end
      return res;
   endfunction

   operand_t op1;
   operand_t op2;
   idex_t    idex_q;
   idex_t    idex_d;
   logic     next_ds;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      op1 = resolve(bus.dec_reg1_read, bus.dec_reg1_addr, bus.reg1_data_i, bus.dec_imm,
                    bus.fwd_wreg_i, bus.fwd_wd_i, bus.fwd_wdata_i, bus.fwd_is_load_i);
      op2 = resolve(bus.dec_reg2_read, bus.dec_reg2_addr, bus.reg2_data_i, bus.dec_imm,
                    bus.fwd_wreg_i, bus.fwd_wd_i, bus.fwd_wdata_i, bus.fwd_is_load_i);

      idex_d         = '0;
      idex_d.valid   = 1'b1;
      idex_d.aluop   = bus.dec_aluop;
      idex_d.alusel  = bus.dec_alusel;
      idex_d.reg1    = op1.data;
      idex_d.reg2    = op2.data;
      idex_d.wd      = bus.dec_wd;
      idex_d.wreg    = bus.dec_wreg;
      idex_d.is_load = bus.dec_is_load;
      idex_d.in_ds   = next_ds;
   end

   assign stallreq_o = bus.dec_valid & (op1.load_hit | op2.load_hit);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idex_q      <= '0;
         next_ds     <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         if (stallreq_o && !stall_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
         end

         if (flush_i) begin
            idex_q  <= '0;
            next_ds <= 1'b0;
         end else if (stall_i) begin
            idex_q  <= idex_q;
         end else if (stallreq_o || !bus.dec_valid) begin
            idex_q  <= '0;
         end else begin
            idex_q  <= idex_d;
            next_ds <= bus.dec_is_branch;
         end
      end
   end

   assign bus.ex_valid_o        = idex_q.valid;
   assign bus.ex_aluop_o        = idex_q.aluop;
   assign bus.ex_alusel_o       = idex_q.alusel;
   assign bus.ex_reg1_o         = idex_q.reg1;
   assign bus.ex_reg2_o         = idex_q.reg2;
   assign bus.ex_wd_o           = idex_q.wd;
   assign bus.ex_wreg_o         = idex_q.wreg;
   assign bus.ex_is_load_o      = idex_q.is_load;
   assign bus.ex_in_delayslot_o = idex_q.in_ds;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_operand_stage;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_FWD  = 3;
   localparam int ALUOP_W  = 8;
   localparam int ALUSEL_W = 3;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall_i;
   logic             flush_i;
   logic             stallreq_o;
   logic [CNT_W-1:0] stall_cnt_o;

   id_operand_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
                         .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) bus ();

   id_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
                      .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .stallreq_o  (stallreq_o),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   logic              f_wreg [NUM_FWD];
   logic [ADDR_W-1:0] f_wd   [NUM_FWD];
   logic [DATA_W-1:0] f_wdata[NUM_FWD];
   logic              f_ld   [NUM_FWD];

   always_comb begin
      bus.fwd_wreg_i    = '0;
      bus.fwd_wd_i      = '0;
      bus.fwd_wdata_i   = '0;
      bus.fwd_is_load_i = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         bus.fwd_wreg_i[k]                   = f_wreg[k];
         bus.fwd_wd_i[k*ADDR_W +: ADDR_W]    = f_wd[k];
         bus.fwd_wdata_i[k*DATA_W +: DATA_W] = f_wdata[k];
         bus.fwd_is_load_i[k]                = f_ld[k];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the EX-side view plus the pending delay-slot flag and counter.
   logic              m_init = 1'b0;
   logic              m_valid, m_wreg, m_ld, m_ds, m_next_ds;
   logic [ALUOP_W-1:0]  m_aluop;
   logic [ALUSEL_W-1:0] m_alusel;
   logic [DATA_W-1:0] m_r1, m_r2;
   logic [ADDR_W-1:0] m_wd;
   int                m_cnt;

   // Scan oldest to youngest so the youngest match is the one left standing.
   function automatic void model_op(input logic rd, input logic [ADDR_W-1:0] a,
                                    input logic [DATA_W-1:0] rf,
                                    output logic [DATA_W-1:0] v, output logic ld);
      v  = rf;
      ld = 1'b0;
      if (!rd) v = bus.dec_imm;
      else if (a == 0) v = '0;
      else begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (f_wreg[k] && f_wd[k] == a) begin
               v  = f_wdata[k];
               ld = f_ld[k];
            end
         end
      end
   endfunction

   function automatic logic model_stallreq();
      logic [DATA_W-1:0] v1, v2;
      logic l1, l2;
      model_op(bus.dec_reg1_read, bus.dec_reg1_addr, bus.reg1_data_i, v1, l1);
      model_op(bus.dec_reg2_read, bus.dec_reg2_addr, bus.reg2_data_i, v2, l2);
      return bus.dec_valid && (l1 || l2);
   endfunction

   task automatic model_bubble();
      m_valid = 0; m_aluop = '0; m_alusel = '0; m_r1 = '0; m_r2 = '0;
      m_wd = '0; m_wreg = 0; m_ld = 0; m_ds = 0;
   endtask

   always @(posedge clk) begin
      logic [DATA_W-1:0] v1, v2;
      logic l1, l2, hz;
      model_op(bus.dec_reg1_read, bus.dec_reg1_addr, bus.reg1_data_i, v1, l1);
      model_op(bus.dec_reg2_read, bus.dec_reg2_addr, bus.reg2_data_i, v2, l2);
      hz = bus.dec_valid && (l1 || l2);
      if (!rst) begin
         model_bubble();
         m_next_ds = 0;
         m_cnt     = 0;
         m_init    = 1'b1;
      end else if (m_init) begin
         if (hz && !stall_i && m_cnt < CNT_MAX) m_cnt++;
         if (flush_i) begin
            model_bubble();
            m_next_ds = 0;
         end else if (stall_i) begin
            // outputs hold
         end else if (hz || !bus.dec_valid) begin
            model_bubble();
         end else begin
            m_valid  = 1; m_aluop = bus.dec_aluop; m_alusel = bus.dec_alusel;
            m_r1     = v1; m_r2 = v2; m_wd = bus.dec_wd; m_wreg = bus.dec_wreg;
            m_ld     = bus.dec_is_load; m_ds = m_next_ds;
            m_next_ds = bus.dec_is_branch;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("stallreq", stallreq_o, model_stallreq());
         check("ex_valid", bus.ex_valid_o, m_valid);
         check("ex_aluop", bus.ex_aluop_o, m_aluop);
         check("ex_alusel", bus.ex_alusel_o, m_alusel);
         check("ex_reg1", bus.ex_reg1_o, m_r1);
         check("ex_reg2", bus.ex_reg2_o, m_r2);
         check("ex_wd", bus.ex_wd_o, m_wd);
         check("ex_wreg", bus.ex_wreg_o, m_wreg);
         check("ex_is_load", bus.ex_is_load_o, m_ld);
         check("ex_delayslot", bus.ex_in_delayslot_o, m_ds);
         check("stall_cnt", stall_cnt_o, m_cnt[CNT_W-1:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.dec_valid = 0; bus.dec_reg1_read = 0; bus.dec_reg2_read = 0;
      bus.dec_reg1_addr = '0; bus.dec_reg2_addr = '0; bus.dec_imm = '0;
      bus.dec_aluop = '0; bus.dec_alusel = '0; bus.dec_wd = '0; bus.dec_wreg = 0;
      bus.dec_is_load = 0; bus.dec_is_branch = 0;
      bus.reg1_data_i = 32'hEEEE_0001; bus.reg2_data_i = 32'hEEEE_0002;
      for (int k = 0; k < NUM_FWD; k++) begin
         f_wreg[k] = 0; f_wd[k] = '0; f_wdata[k] = '0; f_ld[k] = 0;
      end
   endtask

   task automatic alu(input logic rd1, input logic [ADDR_W-1:0] a1,
                      input logic rd2, input logic [ADDR_W-1:0] a2,
                      input logic [DATA_W-1:0] imm, input logic br);
      bus.dec_valid = 1; bus.dec_reg1_read = rd1; bus.dec_reg1_addr = a1;
      bus.dec_reg2_read = rd2; bus.dec_reg2_addr = a2; bus.dec_imm = imm;
      bus.dec_aluop = 8'h21; bus.dec_alusel = 3'd1; bus.dec_wd = 5'd9;
      bus.dec_wreg = 1; bus.dec_is_load = 0; bus.dec_is_branch = br;
   endtask

   task automatic set_fwd(input int k, input logic [ADDR_W-1:0] wd,
                          input logic [DATA_W-1:0] d, input logic ld);
      f_wreg[k] = 1; f_wd[k] = wd; f_wdata[k] = d; f_ld[k] = ld;
   endtask

   initial begin
      rst = 0; stall_i = 0; flush_i = 0;
      idle();
      tick(); tick();
      check("reset_valid", bus.ex_valid_o, 0);
      check("reset_cnt", stall_cnt_o, 0);
      rst = 1;

      // Forwarding from source0, immediate on operand 2
      idle(); alu(1, 5'd3, 0, 5'd0, 32'h77, 0); set_fwd(0, 5'd3, 32'h1234, 0);
      tick();
      check("fwd_src0", bus.ex_reg1_o, 32'h1234);
      check("imm_op2", bus.ex_reg2_o, 32'h77);
      check("valid_alu", bus.ex_valid_o, 1);

      // Two sources write r3: youngest wins
      idle(); alu(1, 5'd3, 1, 5'd7, 32'h0, 0);
      set_fwd(0, 5'd3, 32'hA, 0); set_fwd(1, 5'd3, 32'hB, 0);
      tick();
      check("fwd_priority", bus.ex_reg1_o, 32'hA);
      check("regfile_op2", bus.ex_reg2_o, 32'hEEEE_0002);

      // r0 never forwarded; immediate ignores matching source
      idle(); alu(1, 5'd0, 0, 5'd3, 32'hDEAD, 0);
      set_fwd(0, 5'd0, 32'hFFFF, 0); set_fwd(1, 5'd3, 32'h5, 0);
      tick();
      check("r0_zero", bus.ex_reg1_o, 32'h0);
      check("imm_pass", bus.ex_reg2_o, 32'hDEAD);

      // Younger load is not masked by older non-load; older load behind younger ALU is harmless
      idle(); alu(1, 5'd6, 0, 5'd0, 32'h0, 0);
      set_fwd(0, 5'd6, 32'h1, 1); set_fwd(1, 5'd6, 32'h2, 0);
      #1 check("young_load_hz", stallreq_o, 1);
      f_ld[0] = 0; f_ld[1] = 1;
      #1 check("old_load_masked", stallreq_o, 0);

      // Load-use: bubble, then MEM forwarding
      idle(); alu(1, 5'd5, 0, 5'd0, 32'h0, 0); set_fwd(0, 5'd5, 32'h0, 1);
      #1 check("loaduse_req", stallreq_o, 1);
      tick();
      check("loaduse_bubble", bus.ex_valid_o, 0);
      idle(); alu(1, 5'd5, 0, 5'd0, 32'h0, 0); set_fwd(1, 5'd5, 32'h55, 0);
      tick();
      check("loaduse_mem_fwd", bus.ex_reg1_o, 32'h55);
      check("loaduse_cnt", stall_cnt_o, 1);

      // Branch then ALU op: delay slot
      idle(); alu(0, 5'd0, 0, 5'd0, 32'h1, 1);
      tick();
      check("branch_not_ds", bus.ex_in_delayslot_o, 0);
      idle(); alu(0, 5'd0, 0, 5'd0, 32'h2, 0);
      tick();
      check("ds_set", bus.ex_in_delayslot_o, 1);

      // Branch, flush, ALU op: flag cleared
      idle(); alu(0, 5'd0, 0, 5'd0, 32'h3, 1);
      tick();
      flush_i = 1; idle(); alu(0, 5'd0, 0, 5'd0, 32'h4, 0);
      tick();
      check("flush_bubble", bus.ex_valid_o, 0);
      flush_i = 0; idle(); alu(0, 5'd0, 0, 5'd0, 32'h99, 0);
      tick();
      check("ds_after_flush", bus.ex_in_delayslot_o, 0);

      // Stall with hazard held 3 cycles, then bubble and count
      idle(); alu(1, 5'd5, 0, 5'd0, 32'h0, 0); set_fwd(0, 5'd5, 32'h0, 1); stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_reg1", bus.ex_reg1_o, 32'h99);
         check("hold_cnt", stall_cnt_o, 1);
      end
      stall_i = 0;
      tick();
      check("post_stall_bubble", bus.ex_valid_o, 0);
      check("post_stall_cnt", stall_cnt_o, 2);

      // Reset in the middle of a stall
      idle(); alu(0, 5'd0, 0, 5'd0, 32'h42, 0);
      tick();
      alu(1, 5'd5, 0, 5'd0, 32'h0, 0); set_fwd(0, 5'd5, 32'h0, 1); stall_i = 1; rst = 0;
      tick();
      check("rst_valid", bus.ex_valid_o, 0);
      check("rst_reg2", bus.ex_reg2_o, 0);
      check("rst_cnt", stall_cnt_o, 0);
      rst = 1; stall_i = 0;

      // Saturation
      repeat (CNT_MAX + 5) tick();
      check("cnt_saturated", stall_cnt_o, CNT_MAX);
      tick();
      check("cnt_stays_sat", stall_cnt_o, CNT_MAX);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst     = ($urandom_range(0, 199) != 0);
         stall_i = ($urandom_range(0, 7) == 0);
         flush_i = ($urandom_range(0, 15) == 0);
         bus.dec_valid     = ($urandom_range(0, 4) != 0);
         bus.dec_reg1_read = $urandom_range(0, 3) != 0;
         bus.dec_reg2_read = $urandom_range(0, 3) != 0;
         bus.dec_reg1_addr = ADDR_W'($urandom_range(0, 3));
         bus.dec_reg2_addr = ADDR_W'($urandom_range(0, 3));
         bus.dec_imm       = $urandom;
         bus.dec_aluop     = ALUOP_W'($urandom);
         bus.dec_alusel    = ALUSEL_W'($urandom);
         bus.dec_wd        = ADDR_W'($urandom);
         bus.dec_wreg      = 1'($urandom);
         bus.dec_is_load   = 1'($urandom);
         bus.dec_is_branch = ($urandom_range(0, 3) == 0);
         bus.reg1_data_i   = $urandom;
         bus.reg2_data_i   = $urandom;
         for (int k = 0; k < NUM_FWD; k++) begin
            f_wreg[k]  = 1'($urandom);
            f_wd[k]    = ADDR_W'($urandom_range(0, 3));
            f_wdata[k] = $urandom;
            f_ld[k]    = ($urandom_range(0, 3) == 0);
         end
         tick();
      end

      idle(); stall_i = 0; flush_i = 0;
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side operand stage, the successor to the current decoder's operand mux. It takes decoded fields for the instruction in ID and resolves both source operands from the register file, from immediates, or from N prioritised forwarding sources. It detects load-use hazards and raises a stall request, and it tracks branch delay slots. Its outputs go through an internal ID/EX pipeline register, so all EX-side outputs are registered; `stallreq_o` is the only combinational output.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- ADDR_W, 5, register address width
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest and has highest priority (EX, then MEM, ...)
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- dec_valid  in  1  ID holds a real instruction
- dec_reg1_read / dec_reg2_read  in  1 each  operand reads register (else immediate)
- dec_reg1_addr / dec_reg2_addr  in  ADDR_W each  source register addresses
- dec_imm  in  DATA_W  extended immediate
- dec_aluop  in  ALUOP_W  ALU sub-op
- dec_alusel  in  ALUSEL_W  result type
- dec_wd  in  ADDR_W  destination register
- dec_wreg  in  1  destination write enable
- dec_is_load  in  1  instruction is a load
- dec_is_branch  in  1  instruction is a branch/jump with delay slot
- reg1_data_i / reg2_data_i  in  DATA_W each  regfile read data
- fwd_wreg_i  in  NUM_FWD  per-source write enable
- fwd_wd_i  in  NUM_FWD*ADDR_W  per-source destination, source k at bits [k*ADDR_W +: ADDR_W]
- fwd_wdata_i  in  NUM_FWD*DATA_W  per-source data
- fwd_is_load_i  in  NUM_FWD  source's data is not yet valid (load not completed)
- stall_i  in  1  downstream/ctrl stall; hold ID/EX register
- flush_i  in  1  kill ID/EX contents
- ex_valid_o  out  1  EX holds a real instruction
- ex_aluop_o  out  ALUOP_W
- ex_alusel_o  out  ALUSEL_W
- ex_reg1_o / ex_reg2_o  out  DATA_W each  resolved operands
- ex_wd_o  out  ADDR_W
- ex_wreg_o  out  1
- ex_is_load_o  out  1
- ex_in_delayslot_o  out  1  EX instruction sits in a delay slot
- stallreq_o  out  1  load-use stall request to ctrl (combinational)
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Operand resolution applies per operand, with the first matching rule taking effect:
  - read=0 gives dec_imm.
  - addr==0 gives 0. Register 0 is never forwarded.
  - Otherwise, the lowest k with fwd_wreg_i[k] and fwd_wd_i[k]==addr gives fwd_wdata_i[k].
  - Otherwise, regfile data is used.
- Load-use hazard exists when, for either operand with read=1 and addr!=0, the selected (lowest matching) source k has fwd_is_load_i[k]=1.
  - stallreq_o = dec_valid & hazard. It is independent of stall_i.
  - An older non-load match does not mask a younger load match. Priority selects, then the load flag of that selection decides.
- The ID/EX register updates on each rising edge, with the first matching condition taking effect:
  1. rst=0 → bubble; the delay-slot flag clears and stall_cnt_o is set to 0.
  2. flush_i=1 → bubble; the delay-slot flag clears.
  3. stall_i=1 → hold all outputs.
  4. stallreq_o=1 → bubble.
  5. Otherwise → load the decoded fields and resolved operands; ex_valid_o=dec_valid.
- A bubble sets ex_valid_o=0, ex_wreg_o=0, ex_is_load_o=0, ex_in_delayslot_o=0, and all other outputs to 0 (aluop 0 = NOP).
- dec_valid=0 on load is treated as a bubble: ex_wreg_o is forced to 0.
- Delay-slot tracking uses an internal flag next_ds.
  - On a load with dec_valid=1: ex_in_delayslot_o<=next_ds and next_ds<=dec_is_branch.
  - On hold or bubble, next_ds is unchanged.
  - Flush and reset clear next_ds.
- stall_cnt_o increments on every edge with stallreq_o=1 and stall_i=0. It saturates at all-ones.

## Timing
- Decode-to-EX latency is 1 cycle. Forwarding and hazard detection are same-cycle combinational.
- When a load is in EX and a dependent instruction is in ID, stallreq_o=1 for that cycle and one bubble is inserted.
  - The next cycle the load is in MEM with fwd_is_load_i cleared, if MEM data is ready. The dependent instruction then advances using MEM forwarding.
- A simultaneous flush_i and stall_i resolves as flush.
- A simultaneous stallreq_o and stall_i resolves as hold: no bubble is inserted and the counter does not increment.
- A reset mid-stall clears everything in that cycle.

## Test plan
- Back-to-back ALU ops: source0 writes r3=0x1234 and ID reads r3 → ex_reg1_o=0x1234 next cycle. With source0 and source1 both writing r3 (0xA, 0xB) → 0xA selected.
- Read r0 while source0 writes r0=0xFFFF → operand 0. Immediate operand with read=0 → dec_imm passes unchanged, even if the address matches a source.
- Load in source0 with fwd_is_load_i[0]=1 writing r5, and ID reads r5 → stallreq_o=1 and a bubble with ex_valid_o=0. Next cycle the load is in source1 with 0x55 and the load flag cleared → operand 0x55, stall_cnt_o=1.
- Branch followed by an ALU op, both accepted → the ALU op reaches EX with ex_in_delayslot_o=1. A flush between them → delay-slot flag is 0.
- stall_i=1 for 3 cycles with a hazard present → outputs held, stall_cnt_o unchanged. Then stall_i=0 → bubble and counter +1.
- Assert rst=0 mid-stall → next edge all outputs 0 and stall_cnt_o=0. Force the counter to all-ones → it stays saturated.
